// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator datapath and its keypad sequencer.
//   num_t            : signed BCD number, value = significand * 10^-exponent,
//                      plus an error flag raised by the arithmetic unit.
//   op_t             : operation codes understood by the arithmetic unit.
//                      Subtraction is issued as OP_ADD with a negated operand B.
//   active_button_t  : decoded keypad event.
//   seq_state_t      : calc_sequencer control states.
// Helpers: neg() flips the sign, plus small button classifiers.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int ExpWidth  = $clog2(NumDigits);
  localparam int SigWidth  = 4 * NumDigits;

  typedef struct packed {
    logic                error;
    logic                sign;
    logic [ExpWidth-1:0] exponent;
    logic [SigWidth-1:0] significand;
  } num_t;

  localparam int NumWidth = $bits(num_t);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_MUL  = 2'd2,
    OP_DIV  = 2'd3
  } op_t;

  typedef enum logic [4:0] {
    B_NONE       = 5'd0,
    B_0          = 5'd1,
    B_1          = 5'd2,
    B_2          = 5'd3,
    B_3          = 5'd4,
    B_4          = 5'd5,
    B_5          = 5'd6,
    B_6          = 5'd7,
    B_7          = 5'd8,
    B_8          = 5'd9,
    B_9          = 5'd10,
    B_DOT        = 5'd11,
    B_OP_ADD     = 5'd12,
    B_OP_SUB     = 5'd13,
    B_OP_MUL     = 5'd14,
    B_OP_DIV     = 5'd15,
    B_OP_EQ      = 5'd16,
    B_OP_PERCENT = 5'd17,
    B_OP_SQRT    = 5'd18,
    B_MEM_PLUS   = 5'd19,
    B_MEM_MINUS  = 5'd20,
    B_MEM_RECALL = 5'd21,
    B_MEM_CLEAR  = 5'd22,
    B_ON         = 5'd23,
    B_OFF        = 5'd24,
    B_UNKNOWN    = 5'd31
  } active_button_t;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ENTRY_A = 3'd1,
    S_OP_WAIT = 3'd2,
    S_ENTRY_B = 3'd3,
    S_EXEC    = 3'd4,
    S_RESULT  = 3'd5,
    S_ERROR   = 3'd6
  } seq_state_t;

  function automatic num_t neg(input num_t x);
    num_t r;
    r      = x;
    r.sign = ~x.sign;
    return r;
  endfunction

  function automatic logic is_digit(input active_button_t b);
    return (b >= B_0) && (b <= B_9);
  endfunction

  function automatic logic [3:0] digit_of(input active_button_t b);
    return 4'(b - B_0);
  endfunction

  // Arithmetic operator keys; B_OP_EQ is deliberately not one of them.
  function automatic logic is_op(input active_button_t b);
    return b inside {B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV};
  endfunction

  function automatic op_t op_of(input active_button_t b);
    case (b)
      B_OP_ADD: return OP_ADD;
      B_OP_SUB: return OP_ADD;
      B_OP_MUL: return OP_MUL;
      B_OP_DIV: return OP_DIV;
      default:  return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_sequencer_if
// Request/acknowledge link between the keypad sequencer and the shared
// arithmetic unit.
//   req    : operation request, held until ack
//   op     : operation code (never OP_NONE while req)
//   a, b   : operands (b already negated for subtraction)
//   ack    : result valid this cycle
//   result : operation result (error flag inside)
// master = sequencer side, slave = arithmetic unit side.
// -----------------------------------------------------------------------------
interface calc_sequencer_if;
  import calc_pkg::*;

  logic req;
  op_t  op;
  num_t a;
  num_t b;
  logic ack;
  num_t result;

  modport master (output req, op, a, b, input ack, result);
  modport slave  (input req, op, a, b, output ack, result);

endinterface

// File: rtl/calc_num_entry.sv
// -----------------------------------------------------------------------------
// calc_num_entry
// Accumulates one operand from keypad digits and the decimal point.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   clear_i         : start from zero this cycle (may combine with an edit,
//                     giving a fresh entry that already holds the first key)
//   load_i          : replace the operand with load_val_i (takes priority)
//   load_val_i      : value to load
//   digit_valid_i   : append digit_i
//   digit_i         : BCD digit
//   dot_i           : decimal point pressed
//   value_o         : current operand
// Rules: at most NumDigits significant digits, leading integer zeros are
// dropped, only the first dot counts, fraction digits stop once the exponent
// reaches NumDigits-1.
// -----------------------------------------------------------------------------
module calc_num_entry
  import calc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       load_i,
  input  num_t       load_val_i,
  input  logic       digit_valid_i,
  input  logic [3:0] digit_i,
  input  logic       dot_i,
  output num_t       value_o
);

  localparam int                    CountWidth = $clog2(NumDigits + 1);
  localparam logic [CountWidth-1:0] CountMax   = CountWidth'(NumDigits);
  localparam logic [ExpWidth-1:0]   ExpMax     = ExpWidth'(NumDigits - 1);

  num_t                  value_q, value_d, base_value;
  logic                  dot_seen_q, dot_seen_d, base_dot;
  logic [CountWidth-1:0] count_q, count_d, base_count;
  logic                  leading_zero, digits_full, frac_full, accept_digit;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    base_value = clear_i ? '0 : value_q;
    base_dot   = clear_i ? 1'b0 : dot_seen_q;
    base_count = clear_i ? '0 : count_q;

    leading_zero = !base_dot && (base_value.significand == '0) && (digit_i == 4'd0);
    digits_full  = (base_count == CountMax);
    frac_full    = base_dot && (base_value.exponent == ExpMax);
    accept_digit = digit_valid_i && !leading_zero && !digits_full && !frac_full;

    value_d    = base_value;
    dot_seen_d = base_dot;
    count_d    = base_count;

    if (load_i) begin
      value_d    = load_val_i;
      dot_seen_d = 1'b0;
      count_d    = '0;
    end else if (accept_digit) begin
      value_d.significand = {base_value.significand[SigWidth-5:0], digit_i};
      count_d             = base_count + 1'b1;
      if (base_dot) begin
        value_d.exponent = base_value.exponent + 1'b1;
      end
    end else if (dot_i) begin
      dot_seen_d = 1'b1;
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside
  // the clocked block and is not in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q    <= '0;
      dot_seen_q <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // the pre-edge values, independent of statement order.
      value_q    <= value_d;
      dot_seen_q <= dot_seen_d;
      count_q    <= count_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Keypad-to-ALU controller: turns button events into operands A and B,
// issues operations to the shared arithmetic unit and owns the display value.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   button_valid_i  : one-cycle pulse, button_i valid
//   button_i        : decoded button
//   busy_o          : operation in flight; button events are dropped
//   alu             : request/ack link to the arithmetic unit (master side)
//   display_o       : value shown on the 7-segment driver
//   display_on_o    : display enabled
//   error_o         : latched arithmetic error
// -----------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    button_valid_i,
  input  active_button_t          button_i,
  output logic                    busy_o,
  calc_sequencer_if.master        alu,
  output num_t                    display_o,
  output logic                    display_on_o,
  output logic                    error_o
);

  seq_state_t state_q;
  op_t        op_q, next_op_q;
  logic       sub_q, next_sub_q;
  logic       display_on_q, error_q;

  num_t a_value, b_value;

  logic press_digit, press_dot, press_entry, press_op, press_eq, press_on, press_off;
  logic a_clear, a_load, a_edit, b_clear, b_edit;

  assign press_digit = button_valid_i && is_digit(button_i);
  assign press_dot   = button_valid_i && (button_i == B_DOT);
  assign press_entry = press_digit || press_dot;
  assign press_op    = button_valid_i && is_op(button_i);
  assign press_eq    = button_valid_i && (button_i == B_OP_EQ);
  assign press_on    = button_valid_i && (button_i == B_ON);
  assign press_off   = button_valid_i && (button_i == B_OFF);

  // Operand strobes. Leaving S_OP_WAIT / S_RESULT on a digit or dot clears
  // the operand and applies that key in the same cycle.
  always_comb begin
    a_clear = 1'b0;
    a_load  = 1'b0;
    a_edit  = 1'b0;
    b_clear = 1'b0;
    b_edit  = 1'b0;
    if (state_q == S_EXEC) begin
      a_load = alu.ack;
    end else if (press_on) begin
      a_clear = 1'b1;
      b_clear = 1'b1;
    end else if (!press_off) begin
      case (state_q)
        S_ENTRY_A: a_edit = 1'b1;
        S_OP_WAIT: begin
          b_clear = press_entry;
          b_edit  = 1'b1;
        end
        S_ENTRY_B: b_edit = 1'b1;
        S_RESULT: begin
          a_clear = press_entry;
          a_edit  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  calc_num_entry u_entry_a (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (a_clear),
    .load_i        (a_load),
    .load_val_i    (alu.result),
    .digit_valid_i (a_edit && press_digit),
    .digit_i       (digit_of(button_i)),
    .dot_i         (a_edit && press_dot),
    .value_o       (a_value)
  );

  calc_num_entry u_entry_b (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (b_clear),
    .load_i        (1'b0),
    .load_val_i    ('0),
    .digit_valid_i (b_edit && press_digit),
    .digit_i       (digit_of(button_i)),
    .dot_i         (b_edit && press_dot),
    .value_o       (b_value)
  );

  // Control FSM. S_EXEC ignores every button, including ON/OFF; only the
  // ack (or reset) leaves it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_OFF;
      op_q         <= OP_NONE;
      sub_q        <= 1'b0;
      next_op_q    <= OP_NONE;
      next_sub_q   <= 1'b0;
      display_on_q <= 1'b0;
      error_q      <= 1'b0;
    end else if (state_q == S_EXEC) begin
      if (alu.ack) begin
        if (alu.result.error) begin
          state_q <= S_ERROR;
          error_q <= 1'b1;
        end else if (next_op_q != OP_NONE) begin
          // Chained operator: the result is already A, continue with it.
          op_q      <= next_op_q;
          sub_q     <= next_sub_q;
          next_op_q <= OP_NONE;
          state_q   <= S_OP_WAIT;
        end else begin
          state_q <= S_RESULT;
        end
      end
    end else if (press_on) begin
      state_q      <= S_ENTRY_A;
      op_q         <= OP_NONE;
      sub_q        <= 1'b0;
      next_op_q    <= OP_NONE;
      next_sub_q   <= 1'b0;
      display_on_q <= 1'b1;
      error_q      <= 1'b0;
    end else if (press_off && (state_q != S_OFF)) begin
      state_q      <= S_OFF;
      display_on_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        S_ENTRY_A, S_RESULT: begin
          if (press_op) begin
            op_q    <= op_of(button_i);
            sub_q   <= (button_i == B_OP_SUB);
            state_q <= S_OP_WAIT;
          end else if (press_entry && (state_q == S_RESULT)) begin
            state_q <= S_ENTRY_A;
          end
        end
        S_OP_WAIT: begin
          if (press_op) begin
            op_q  <= op_of(button_i);
            sub_q <= (button_i == B_OP_SUB);
          end else if (press_entry) begin
            state_q <= S_ENTRY_B;
          end
        end
        S_ENTRY_B: begin
          if (press_eq) begin
            next_op_q  <= OP_NONE;
            next_sub_q <= 1'b0;
            state_q    <= S_EXEC;
          end else if (press_op) begin
            next_op_q  <= op_of(button_i);
            next_sub_q <= (button_i == B_OP_SUB);
            state_q    <= S_EXEC;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_q == S_EXEC);
  assign alu.req      = (state_q == S_EXEC);
  assign alu.op       = op_q;
  assign alu.a        = a_value;
  assign alu.b        = sub_q ? neg(b_value) : b_value;
  assign display_on_o = display_on_q;
  assign error_o      = error_q;

  // Display follows the operand being edited; A holds results.
  always_comb begin
    case (state_q)
      S_OFF:     display_o = '0;
      S_ENTRY_B: display_o = b_value;
      default:   display_o = a_value;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  import calc_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           button_valid;
  active_button_t button;
  logic           busy;
  num_t           display;
  logic           display_on;
  logic           error;

  calc_sequencer_if alu_if();

  calc_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .button_valid_i (button_valid),
    .button_i       (button),
    .busy_o         (busy),
    .alu            (alu_if),
    .display_o      (display),
    .display_on_o   (display_on),
    .error_o        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Arithmetic unit model: acks alu_delay cycles after req rises.
  int   alu_delay = 1;
  bit   alu_hold  = 1'b0;
  bit   stray_ack = 1'b0;
  num_t alu_resp  = '0;
  int   req_cnt   = 0;
  int   req_len   = 0;

  always @(negedge clk) begin
    if (alu_if.req && !alu_if.ack) begin
      req_cnt = req_cnt + 1;
      if (!alu_hold && req_cnt >= alu_delay) begin
        alu_if.ack    = 1'b1;
        alu_if.result = alu_resp;
        req_len       = req_cnt;
      end
    end else begin
      alu_if.ack    = stray_ack;
      alu_if.result = alu_resp;
      req_cnt       = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic num_t mk(input logic [31:0] sig, input int e);
    num_t n;
    n             = '0;
    n.significand = sig;
    n.exponent    = ExpWidth'(e);
    return n;
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference entry model: decimal integer plus fraction count.
  function automatic num_t model_entry(input active_button_t keys[$]);
    int unsigned val;
    int          ndig, frac, d;
    bit          dot;
    val = 0; ndig = 0; frac = 0; dot = 1'b0;
    foreach (keys[i]) begin
      if (keys[i] >= B_0 && keys[i] <= B_9) begin
        d = int'(keys[i]) - int'(B_0);
        if (!dot && val == 0 && d == 0) continue;
        if (ndig == 8) continue;
        if (dot && frac == 7) continue;
        val  = val * 10 + d;
        ndig = ndig + 1;
        if (dot) frac = frac + 1;
      end else if (keys[i] == B_DOT) begin
        dot = 1'b1;
      end
    end
    return mk(to_bcd(val), frac);
  endfunction

  function automatic op_t expect_op(input active_button_t b);
    if (b == B_OP_MUL) return OP_MUL;
    if (b == B_OP_DIV) return OP_DIV;
    return OP_ADD;
  endfunction

  function automatic active_button_t digit_btn(input int d);
    return active_button_t'(int'(B_0) + d);
  endfunction

  task automatic press(input active_button_t b);
    @(negedge clk);
    button_valid = 1'b1;
    button       = b;
    @(negedge clk);
    button_valid = 1'b0;
    button       = B_NONE;
  endtask

  task automatic check_disp(input string name, input num_t n, input bit on, input bit err);
    check(name, {display, display_on, error, busy}, {n, on, err, 1'b0});
  endtask

  task automatic wait_exec_done(input string name);
    for (int i = 0; i < 20 && alu_if.req; i++) @(negedge clk);
    check(name, 64'(alu_if.req), 64'd0);
  endtask

  task automatic press_seq(input active_button_t keys[$]);
    foreach (keys[i]) press(keys[i]);
  endtask

  typedef struct {
    active_button_t btn;
    logic [31:0]    sig;
    int             e;
    bit             on;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input active_button_t b, input logic [31:0] s, input int e, input bit on);
    vec_t v;
    v.btn = b; v.sig = s; v.e = e; v.on = on;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0]    sig;
    active_button_t keys_a[$], keys_b[$];
    active_button_t opb, k;
    num_t           exp_a, exp_b, resp;
    int             r;

    rst_n        = 1'b0;
    button_valid = 1'b0;
    button       = B_NONE;
    repeat (2) @(negedge clk);
    check_disp("reset_out", '0, 1'b0, 1'b0);
    check("reset_req", 64'(alu_if.req), 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(S_OFF));
    rst_n = 1'b1;

    // ---- table-driven entry vectors ----
    add(B_5, 32'h0, 0, 1'b0);              // ignored while off
    add(B_ON, 32'h0, 0, 1'b1);
    add(B_1, 32'h1, 0, 1'b1);
    add(B_DOT, 32'h1, 0, 1'b1);
    add(B_5, 32'h15, 1, 1'b1);
    add(B_DOT, 32'h15, 1, 1'b1);           // second dot ignored
    add(B_2, 32'h152, 2, 1'b1);
    add(B_MEM_PLUS, 32'h152, 2, 1'b1);
    add(B_OP_SQRT, 32'h152, 2, 1'b1);
    add(B_OP_PERCENT, 32'h152, 2, 1'b1);
    add(B_UNKNOWN, 32'h152, 2, 1'b1);
    add(B_NONE, 32'h152, 2, 1'b1);
    add(B_ON, 32'h0, 0, 1'b1);
    add(B_0, 32'h0, 0, 1'b1);
    add(B_0, 32'h0, 0, 1'b1);
    sig = '0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sig = (sig << 4) | 32'(i);
      add(digit_btn(i), sig, 0, 1'b1);
    end
    add(B_ON, 32'h0, 0, 1'b1);
    add(B_DOT, 32'h0, 0, 1'b1);
    sig = '0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= 7) sig = (sig << 4) | 32'(i);
      add(digit_btn(i), sig, (i <= 7) ? i : 7, 1'b1);
    end
    add(B_ON, 32'h0, 0, 1'b1);
    add(B_DOT, 32'h0, 0, 1'b1);
    add(B_0, 32'h0, 1, 1'b1);
    add(B_5, 32'h5, 2, 1'b1);
    add(B_OFF, 32'h0, 0, 1'b0);
    add(B_7, 32'h0, 0, 1'b0);

    foreach (vecs[i]) begin
      press(vecs[i].btn);
      check_disp($sformatf("vec%0d", i), mk(vecs[i].sig, vecs[i].e), vecs[i].on, 1'b0);
    end

    // ---- 12 + 3 = 15 with 3-cycle ALU latency ----
    press_seq('{B_ON, B_1, B_2, B_OP_ADD, B_3});
    check_disp("s1_b_disp", mk(32'h3, 0), 1'b1, 1'b0);
    alu_resp  = mk(32'h15, 0);
    alu_delay = 3;
    press(B_OP_EQ);
    check("s1_req_lat", 64'(alu_if.req), 64'd1);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_op", 64'(alu_if.op), 64'(OP_ADD));
    check("s1_a", 64'(alu_if.a), 64'(mk(32'h12, 0)));
    check("s1_b", 64'(alu_if.b), 64'(mk(32'h3, 0)));
    wait_exec_done("s1_done");
    check_disp("s1_result", mk(32'h15, 0), 1'b1, 1'b0);
    check("s1_req_len", 64'(req_len), 64'd3);
    check("s1_state", 64'(dut.state_q), 64'(S_RESULT));
    alu_resp = mk(32'h99, 0);
    @(posedge clk); #1 stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    @(negedge clk);
    check_disp("stray_ack", mk(32'h15, 0), 1'b1, 1'b0);
    press(B_OP_EQ);
    check("s1_eq_ignored", 64'(dut.state_q), 64'(S_RESULT));
    press(B_OP_ADD);
    check("s1_opwait", 64'(dut.state_q), 64'(S_OP_WAIT));
    check_disp("s1_a_kept", mk(32'h15, 0), 1'b1, 1'b0);
    press(B_2);
    check_disp("s1_fresh_b", mk(32'h2, 0), 1'b1, 1'b0);

    // ---- 9 - 4 issued as ADD with negated B ----
    press_seq('{B_ON, B_9, B_OP_SUB, B_4});
    alu_resp  = mk(32'h5, 0);
    alu_delay = 3;
    press(B_OP_EQ);
    check("s2_op", 64'(alu_if.op), 64'(OP_ADD));
    check("s2_a", 64'(alu_if.a), 64'(mk(32'h9, 0)));
    check("s2_b", 64'(alu_if.b), 64'({1'b0, 1'b1, 3'd0, 32'h4}));
    wait_exec_done("s2_done");
    check("s2_req_len", 64'(req_len), 64'd3);
    check_disp("s2_result", mk(32'h5, 0), 1'b1, 1'b0);

    // ---- 8 / 0 -> error ----
    resp       = mk(32'h0, 0);
    resp.error = 1'b1;
    press_seq('{B_ON, B_8, B_OP_DIV, B_0});
    alu_resp  = resp;
    alu_delay = 2;
    press(B_OP_EQ);
    check("s3_op", 64'(alu_if.op), 64'(OP_DIV));
    wait_exec_done("s3_done");
    check_disp("s3_error", resp, 1'b1, 1'b1);
    press_seq('{B_5, B_OP_ADD, B_DOT});
    check_disp("s3_ignored", resp, 1'b1, 1'b1);
    check("s3_state", 64'(dut.state_q), 64'(S_ERROR));
    press(B_ON);
    check_disp("s3_on_clears", '0, 1'b1, 1'b0);
    press_seq('{B_8, B_OP_DIV, B_0, B_OP_EQ});
    wait_exec_done("s3b_done");
    press(B_OFF);
    check_disp("s3_off_clears", '0, 1'b0, 1'b0);

    // ---- buttons dropped in EXEC, reset aborts EXEC ----
    alu_hold = 1'b1;
    press_seq('{B_ON, B_5, B_OP_ADD, B_5, B_OP_EQ});
    press(B_7);
    press(B_OFF);
    check("s4_busy", {60'd0, busy, display_on, alu_if.req, error}, 64'b1110);
    check("s4_a_stable", 64'(alu_if.a), 64'(mk(32'h5, 0)));
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("s4_rst_req", 64'(alu_if.req), 64'd0);
    check("s4_rst_state", 64'(dut.state_q), 64'(S_OFF));
    check_disp("s4_rst_out", '0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    alu_hold = 1'b0;

    // ---- chained 2 * 3 + 4 = ----
    press_seq('{B_ON, B_2, B_OP_MUL, B_3});
    alu_resp  = mk(32'h6, 0);
    alu_delay = 1;
    press(B_OP_ADD);
    check("s5_op", 64'(alu_if.op), 64'(OP_MUL));
    check("s5_ab", {alu_if.a, alu_if.b}, {mk(32'h2, 0), mk(32'h3, 0)});
    wait_exec_done("s5_done");
    check_disp("s5_result", mk(32'h6, 0), 1'b1, 1'b0);
    check("s5_state", 64'(dut.state_q), 64'(S_OP_WAIT));
    press(B_4);
    alu_resp  = mk(32'h10, 0);
    alu_delay = 2;
    press(B_OP_EQ);
    check("s5_op2", 64'(alu_if.op), 64'(OP_ADD));
    check("s5_ab2", {alu_if.a, alu_if.b}, {mk(32'h6, 0), mk(32'h4, 0)});
    wait_exec_done("s5_done2");
    check_disp("s5_result2", mk(32'h10, 0), 1'b1, 1'b0);

    // ---- randomized A op B = against the entry model ----
    for (int it = 0; it < 30; it++) begin
      keys_a.delete();
      keys_b.delete();
      press(B_ON);
      for (int j = 0; j < int'($urandom_range(0, 11)); j++) begin
        r = $urandom_range(0, 14);
        if (r < 10)       k = digit_btn(r);
        else if (r < 12)  k = B_DOT;
        else if (r == 12) k = B_MEM_PLUS;
        else if (r == 13) k = B_OP_PERCENT;
        else              k = B_UNKNOWN;
        keys_a.push_back(k);
      end
      press_seq(keys_a);
      exp_a = model_entry(keys_a);
      check($sformatf("rnd%0d_a", it), 64'(display), 64'(exp_a));
      r = $urandom_range(0, 3);
      opb = (r == 0) ? B_OP_ADD : (r == 1) ? B_OP_SUB : (r == 2) ? B_OP_MUL : B_OP_DIV;
      press(opb);
      r = $urandom_range(0, 10);
      keys_b.push_back((r < 10) ? digit_btn(r) : B_DOT);
      for (int j = 0; j < int'($urandom_range(0, 10)); j++) begin
        r = $urandom_range(0, 12);
        keys_b.push_back((r < 10) ? digit_btn(r) : (r < 12) ? B_DOT : B_MEM_CLEAR);
      end
      press_seq(keys_b);
      exp_b = model_entry(keys_b);
      check($sformatf("rnd%0d_b", it), 64'(display), 64'(exp_b));
      resp             = '0;
      resp.significand = to_bcd($urandom_range(0, 99999999));
      resp.exponent    = ExpWidth'($urandom_range(0, 7));
      resp.sign        = 1'($urandom_range(0, 1));
      alu_resp         = resp;
      alu_delay        = $urandom_range(1, 4);
      press(B_OP_EQ);
      exp_b.sign = (opb == B_OP_SUB);
      check($sformatf("rnd%0d_op", it), 64'(alu_if.op), 64'(expect_op(opb)));
      check($sformatf("rnd%0d_alu_a", it), 64'(alu_if.a), 64'(exp_a));
      check($sformatf("rnd%0d_alu_b", it), 64'(alu_if.b), 64'(exp_b));
      wait_exec_done($sformatf("rnd%0d_done", it));
      check($sformatf("rnd%0d_len", it), 64'(req_len), 64'(alu_delay));
      check_disp($sformatf("rnd%0d_res", it), resp, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
